// File: rtl/uart_rx_top_if.sv
// UART receiver port bundle: serial line plus frame config in, parallel word and status strobes out.
interface uart_rx_top_if #(
    parameter int unsigned WIDTH_DATA = 8
);
    logic                  RX_IN;
    logic [5:0]            PRESCALE;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [WIDTH_DATA-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_ERR;
    logic                  STP_ERR;
    logic                  BUSY;

    modport master (
        output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY
    );

    modport slave (
        input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        output P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY
    );
endinterface

// File: rtl/uart_rx_top.sv
// UART receiver: oversampled start/data/parity/stop deframing with 3-sample majority vote,
// emitting a good word with a DATA_VALID strobe or flagging PAR_ERR / STP_ERR.
module uart_rx_top #(
    parameter int unsigned WIDTH_DATA = 8
) (
    input  logic          CLK_TOP,
    input  logic          RST_TOP,
    uart_rx_top_if.slave  rx_bus
);
    localparam int unsigned PW = 6;
    localparam int unsigned BW = (WIDTH_DATA > 1) ? $clog2(WIDTH_DATA) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state;
    logic [PW-1:0]         edge_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [PW-1:0]         presc_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [2:0]            samp;
    logic [WIDTH_DATA-1:0] data_q;
    logic                  par_fail;

    logic [PW-1:0]         half;
    logic                  last_edge;
    logic                  vote;

    // Bit timing is derived from the prescale captured at start detection.
    assign half      = {1'b0, presc_q[PW-1:1]};
    assign last_edge = (edge_cnt == presc_q - PW'(1));
    assign vote      = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);

    always_ff @(posedge CLK_TOP) begin
        if (RST_TOP) begin
            state             <= S_IDLE;
            edge_cnt          <= '0;
            bit_cnt           <= '0;
            presc_q           <= '0;
            par_en_q          <= 1'b0;
            par_typ_q         <= 1'b0;
            samp              <= '0;
            data_q            <= '0;
            par_fail          <= 1'b0;
            rx_bus.P_DATA     <= '0;
            rx_bus.DATA_VALID <= 1'b0;
            rx_bus.PAR_ERR    <= 1'b0;
            rx_bus.STP_ERR    <= 1'b0;
            rx_bus.BUSY       <= 1'b0;
        end else begin
            rx_bus.DATA_VALID <= 1'b0;
            rx_bus.PAR_ERR    <= 1'b0;
            rx_bus.STP_ERR    <= 1'b0;
            rx_bus.BUSY       <= 1'b1;

            // Three mid-bit samples feed the vote used at the bit's last edge.
            if (state != S_IDLE) begin
                edge_cnt <= last_edge ? '0 : edge_cnt + PW'(1);
                if (edge_cnt == half - PW'(1)) samp[0] <= rx_bus.RX_IN;
                if (edge_cnt == half)          samp[1] <= rx_bus.RX_IN;
                if (edge_cnt == half + PW'(1)) samp[2] <= rx_bus.RX_IN;
            end

            case (state)
                S_IDLE: begin
                    rx_bus.BUSY <= ~rx_bus.RX_IN;
                    if (!rx_bus.RX_IN) begin
                        state     <= S_START;
                        edge_cnt  <= PW'(1);
                        bit_cnt   <= '0;
                        presc_q   <= rx_bus.PRESCALE;
                        par_en_q  <= rx_bus.PAR_EN;
                        par_typ_q <= rx_bus.PAR_TYP;
                        par_fail  <= 1'b0;
                    end
                end
                S_START: begin
                    if (last_edge) state <= vote ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (last_edge) begin
                        data_q[bit_cnt] <= vote;
                        if (bit_cnt == BW'(WIDTH_DATA - 1)) begin
                            state <= par_en_q ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (last_edge) begin
                        par_fail <= vote ^ (^data_q) ^ par_typ_q;
                        state    <= S_STOP;
                    end
                end
                S_STOP: begin
                    // Frame verdict: errors suppress the word, P_DATA holds the last good one.
                    if (last_edge) begin
                        state <= S_IDLE;
                        if (!vote)    rx_bus.STP_ERR <= 1'b1;
                        if (par_fail) rx_bus.PAR_ERR <= 1'b1;
                        if (vote && !par_fail) begin
                            rx_bus.P_DATA     <= data_q;
                            rx_bus.DATA_VALID <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_top.sv
// Scoreboard bench for uart_rx_top: expected strobes queued as frames are driven,
// matched in order against strobes captured by a negedge monitor.
module tb_uart_rx_top;
    typedef struct packed {
        logic [7:0]  pdata;
        logic        dv;
        logic        pe;
        logic        se;
        logic [31:0] cyc;
    } ev_t;

    logic CLK_TOP = 1'b0;
    logic RST_TOP = 1'b1;
    uart_rx_top_if #(.WIDTH_DATA(8)) bus ();

    uart_rx_top #(.WIDTH_DATA(8)) dut (
        .CLK_TOP (CLK_TOP),
        .RST_TOP (RST_TOP),
        .rx_bus  (bus.slave)
    );

    always #5 CLK_TOP = ~CLK_TOP;

    int   cyc = 0;
    int   busy_cnt = 0;
    int   obs_n = 0;
    ev_t  obs [64];
    ev_t  sb [$];
    int   rd = 0;
    int   total = 0;
    int   bad = 0;
    logic [7:0] last_good = 8'h00;

    always @(posedge CLK_TOP) cyc <= cyc + 1;

    // Capture every strobe cycle with its timestamp.
    always @(negedge CLK_TOP) begin
        if (bus.BUSY === 1'b1) busy_cnt = busy_cnt + 1;
        if (bus.DATA_VALID !== 1'b0 || bus.PAR_ERR !== 1'b0 || bus.STP_ERR !== 1'b0) begin
            if (obs_n < 64) obs[obs_n] = {bus.P_DATA, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR, 32'(cyc)};
            obs_n = obs_n + 1;
        end
    end

    // Drive one frame; par_ovr < 0 sends correct parity, otherwise forces the bit.
    task automatic send_frame(input logic [7:0] d, input int p, input logic pen, input logic typ,
                              input int par_ovr, input logic stop_bit, input int glitch_c,
                              input int abort_c);
        int   nbits;
        int   len;
        int   start_cyc;
        logic pbit;
        logic v;
        ev_t  e;
        nbits = pen ? 11 : 10;
        len   = p * nbits;
        pbit  = (par_ovr < 0) ? ((^d) ^ typ) : (par_ovr != 0);
        for (int c = 0; c < len; c++) begin
            if (c == 0) @(posedge CLK_TOP);
            else        @(posedge CLK_TOP);
            #1;
            if (c == abort_c) begin
                RST_TOP = 1'b1;
                bus.RX_IN = 1'b1;
                @(posedge CLK_TOP);
                #1;
                RST_TOP = 1'b0;
                last_good = 8'h00;
                return;
            end
            if (c == 0) begin
                start_cyc    = cyc;
                bus.PRESCALE = 6'(p);
                bus.PAR_EN   = pen;
                bus.PAR_TYP  = typ;
                if (abort_c < 0) begin
                    e.se  = ~stop_bit;
                    e.pe  = pen && (pbit != ((^d) ^ typ));
                    e.dv  = ~e.se & ~e.pe;
                    if (e.dv) last_good = d;
                    e.pdata = last_good;
                    e.cyc   = 32'(start_cyc + len);
                    sb.push_back(e);
                end
            end
            if (c == 1) begin
                bus.PRESCALE = (p == 16) ? 6'd8 : 6'd16;
                bus.PAR_EN   = ~pen;
                bus.PAR_TYP  = ~typ;
            end
            if (c < p)                 v = 1'b0;
            else if (c < 9 * p)        v = d[(c / p) - 1];
            else if (pen && c < 10 * p) v = pbit;
            else                       v = stop_bit;
            if (c == glitch_c) v = ~v;
            bus.RX_IN = v;
        end
    endtask

    task automatic test_reset();
        bus.RX_IN = 1'b1; bus.PRESCALE = 6'd8; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
        RST_TOP = 1'b1;
        repeat (3) @(posedge CLK_TOP);
        #1;
        total++; if (bus.P_DATA !== 8'h00) begin bad++; $display("FAIL rst_pdata got=%h want=00", bus.P_DATA); end
        total++; if (bus.DATA_VALID !== 1'b0) begin bad++; $display("FAIL rst_dv got=%b want=0", bus.DATA_VALID); end
        total++; if (bus.PAR_ERR !== 1'b0) begin bad++; $display("FAIL rst_pe got=%b want=0", bus.PAR_ERR); end
        total++; if (bus.STP_ERR !== 1'b0) begin bad++; $display("FAIL rst_se got=%b want=0", bus.STP_ERR); end
        total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.BUSY); end
        RST_TOP = 1'b0;
        last_good = 8'h00;
        repeat (2) @(posedge CLK_TOP);
    endtask

    task automatic test_p8_noparity();
        int  b0;
        ev_t e, g;
        b0 = busy_cnt;
        send_frame(8'hA5, 8, 1'b0, 1'b0, -1, 1'b1, -1, -1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            for (int k = 0; k < 3000 && obs_n <= rd; k++) @(negedge CLK_TOP);
            total++;
            if (obs_n <= rd) begin bad++; $display("FAIL p8_strobe got=none want=%h/%b%b%b@%0d", e.pdata, e.dv, e.pe, e.se, e.cyc); end
            else begin
                g = obs[rd]; rd++;
                if (g !== e) begin bad++; $display("FAIL p8_strobe got=%h/%b%b%b@%0d want=%h/%b%b%b@%0d", g.pdata, g.dv, g.pe, g.se, g.cyc, e.pdata, e.dv, e.pe, e.se, e.cyc); end
            end
        end
        repeat (10) @(negedge CLK_TOP);
        total++; if (obs_n != rd) begin bad++; $display("FAIL p8_extra got=%0d want=%0d", obs_n, rd); rd = obs_n; end
        total++; if (busy_cnt - b0 != 80) begin bad++; $display("FAIL p8_busy got=%0d want=80", busy_cnt - b0); end
    endtask

    task automatic test_parity_even();
        ev_t e, g;
        send_frame(8'h3C, 16, 1'b1, 1'b0, 0, 1'b1, -1, -1);
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1, 1'b1, -1, -1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            for (int k = 0; k < 3000 && obs_n <= rd; k++) @(negedge CLK_TOP);
            total++;
            if (obs_n <= rd) begin bad++; $display("FAIL par_strobe got=none want=%h/%b%b%b@%0d", e.pdata, e.dv, e.pe, e.se, e.cyc); end
            else begin
                g = obs[rd]; rd++;
                if (g !== e) begin bad++; $display("FAIL par_strobe got=%h/%b%b%b@%0d want=%h/%b%b%b@%0d", g.pdata, g.dv, g.pe, g.se, g.cyc, e.pdata, e.dv, e.pe, e.se, e.cyc); end
            end
        end
        repeat (10) @(negedge CLK_TOP);
        total++; if (obs_n != rd) begin bad++; $display("FAIL par_extra got=%0d want=%0d", obs_n, rd); rd = obs_n; end
        total++; if (bus.P_DATA !== 8'h3C) begin bad++; $display("FAIL par_hold got=%h want=3c", bus.P_DATA); end
    endtask

    task automatic test_stop_err();
        ev_t e, g;
        send_frame(8'hFF, 32, 1'b1, 1'b1, -1, 1'b0, -1, -1);
        @(posedge CLK_TOP); #1; bus.RX_IN = 1'b1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            for (int k = 0; k < 3000 && obs_n <= rd; k++) @(negedge CLK_TOP);
            total++;
            if (obs_n <= rd) begin bad++; $display("FAIL stp_strobe got=none want=%h/%b%b%b@%0d", e.pdata, e.dv, e.pe, e.se, e.cyc); end
            else begin
                g = obs[rd]; rd++;
                if (g !== e) begin bad++; $display("FAIL stp_strobe got=%h/%b%b%b@%0d want=%h/%b%b%b@%0d", g.pdata, g.dv, g.pe, g.se, g.cyc, e.pdata, e.dv, e.pe, e.se, e.cyc); end
            end
        end
        repeat (40) @(negedge CLK_TOP);
        total++; if (obs_n != rd) begin bad++; $display("FAIL stp_extra got=%0d want=%0d", obs_n, rd); rd = obs_n; end
        total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL stp_idle busy got=%b want=0", bus.BUSY); end
    endtask

    task automatic test_start_glitch();
        int b0;
        int n0;
        bus.PRESCALE = 6'd16; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
        @(posedge CLK_TOP); #1;
        b0 = busy_cnt; n0 = obs_n;
        bus.RX_IN = 1'b0;
        repeat (3) begin @(posedge CLK_TOP); #1; end
        bus.RX_IN = 1'b1;
        repeat (30) @(negedge CLK_TOP);
        total++; if (busy_cnt - b0 != 16) begin bad++; $display("FAIL glitch_busy got=%0d want=16", busy_cnt - b0); end
        total++; if (obs_n != n0) begin bad++; $display("FAIL glitch_strobes got=%0d want=0", obs_n - n0); rd = obs_n; end
        total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL glitch_idle busy got=%b want=0", bus.BUSY); end
    endtask

    task automatic test_majority();
        ev_t e, g;
        send_frame(8'h00, 16, 1'b0, 1'b0, -1, 1'b1, 16 + 8, -1);
        send_frame(8'h81, 8, 1'b1, 1'b1, -1, 1'b1, 8 * 3 + 3, -1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            for (int k = 0; k < 3000 && obs_n <= rd; k++) @(negedge CLK_TOP);
            total++;
            if (obs_n <= rd) begin bad++; $display("FAIL maj_strobe got=none want=%h/%b%b%b@%0d", e.pdata, e.dv, e.pe, e.se, e.cyc); end
            else begin
                g = obs[rd]; rd++;
                if (g !== e) begin bad++; $display("FAIL maj_strobe got=%h/%b%b%b@%0d want=%h/%b%b%b@%0d", g.pdata, g.dv, g.pe, g.se, g.cyc, e.pdata, e.dv, e.pe, e.se, e.cyc); end
            end
        end
        repeat (10) @(negedge CLK_TOP);
        total++; if (obs_n != rd) begin bad++; $display("FAIL maj_extra got=%0d want=%0d", obs_n, rd); rd = obs_n; end
    endtask

    task automatic test_back_to_back();
        ev_t e, g;
        send_frame(8'h12, 16, 1'b0, 1'b0, -1, 1'b1, -1, -1);
        send_frame(8'h34, 16, 1'b0, 1'b0, -1, 1'b1, -1, -1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            for (int k = 0; k < 3000 && obs_n <= rd; k++) @(negedge CLK_TOP);
            total++;
            if (obs_n <= rd) begin bad++; $display("FAIL b2b_strobe got=none want=%h/%b%b%b@%0d", e.pdata, e.dv, e.pe, e.se, e.cyc); end
            else begin
                g = obs[rd]; rd++;
                if (g !== e) begin bad++; $display("FAIL b2b_strobe got=%h/%b%b%b@%0d want=%h/%b%b%b@%0d", g.pdata, g.dv, g.pe, g.se, g.cyc, e.pdata, e.dv, e.pe, e.se, e.cyc); end
            end
        end
        repeat (10) @(negedge CLK_TOP);
        total++; if (obs_n != rd) begin bad++; $display("FAIL b2b_extra got=%0d want=%0d", obs_n, rd); rd = obs_n; end
        total++; if (rd >= 2 && obs[rd-1].cyc - obs[rd-2].cyc != 32'd160) begin
            bad++; $display("FAIL b2b_spacing got=%0d want=160", obs[rd-1].cyc - obs[rd-2].cyc);
        end
    endtask

    task automatic test_reset_abort();
        ev_t e, g;
        send_frame(8'h9A, 16, 1'b0, 1'b0, -1, 1'b1, -1, 50);
        #1;
        total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", bus.BUSY); end
        total++; if (bus.P_DATA !== 8'h00) begin bad++; $display("FAIL abort_pdata got=%h want=00", bus.P_DATA); end
        repeat (200) @(negedge CLK_TOP);
        total++; if (obs_n != rd) begin bad++; $display("FAIL abort_strobe got=%0d want=0", obs_n - rd); rd = obs_n; end
        send_frame(8'h56, 16, 1'b0, 1'b0, -1, 1'b1, -1, -1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            for (int k = 0; k < 3000 && obs_n <= rd; k++) @(negedge CLK_TOP);
            total++;
            if (obs_n <= rd) begin bad++; $display("FAIL abort_next got=none want=%h/%b%b%b@%0d", e.pdata, e.dv, e.pe, e.se, e.cyc); end
            else begin
                g = obs[rd]; rd++;
                if (g !== e) begin bad++; $display("FAIL abort_next got=%h/%b%b%b@%0d want=%h/%b%b%b@%0d", g.pdata, g.dv, g.pe, g.se, g.cyc, e.pdata, e.dv, e.pe, e.se, e.cyc); end
            end
        end
        repeat (10) @(negedge CLK_TOP);
        total++; if (obs_n != rd) begin bad++; $display("FAIL abort_extra got=%0d want=%0d", obs_n, rd); rd = obs_n; end
    endtask

    initial begin
        test_reset();
        test_p8_noparity();
        test_parity_even();
        test_stop_err();
        test_start_glitch();
        test_majority();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
